// File: rtl/operand_loader.sv
// Hex-keypad operand loader: collects two N-bit operands nibble by nibble and hands them to the adder.
// Optional build macro SPECIAL_OPERAND_CHECK_EN rejects operands whose exponent field is all ones.
module operand_loader #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   nibble_in,
  input  logic         nibble_strobe,
  input  logic         nibble_del,
  input  logic         op_ready,
  output logic [N-1:0] op_a,
  output logic [N-1:0] op_b,
  output logic         op_valid,
  output logic [1:0]   load_state,
  output logic [2:0]   nib_count,
  output logic         op_error
);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    VALID  = 2'd2,
    ERROR  = 2'd3
  } state_t;

`ifdef SPECIAL_OPERAND_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  state_t       r_state, w_next_state;
  logic [N-1:0] r_op_a, r_op_b, w_next_a, w_next_b;
  logic [N-1:0] w_active, w_shl, w_shr;
  logic [2:0]   r_nib_count, w_next_count;
  logic         r_op_valid, r_op_error;

  function automatic logic is_special(input logic [N-1:0] v);
    return (v[30:23] == 8'hFF);
  endfunction

  assign w_active = (r_state == LOAD_B) ? r_op_b : r_op_a;
  assign w_shl    = {w_active[N-5:0], nibble_in};
  assign w_shr    = {4'h0, w_active[N-1:4]};

  // Next-state and operand update logic; a strobe always wins over a delete
  always_comb begin
    w_next_state = r_state;
    w_next_a     = r_op_a;
    w_next_b     = r_op_b;
    w_next_count = r_nib_count;
    case (r_state)
      LOAD_A, LOAD_B: begin
        if (nibble_strobe) begin
          if (r_state == LOAD_A) begin
            w_next_a = w_shl;
          end else begin
            w_next_b = w_shl;
          end
          if (r_nib_count == 3'd7) begin
            w_next_count = 3'd0;
            if (r_state == LOAD_A) begin
              w_next_state = LOAD_B;
            end else if (CHECK_EN && (is_special(r_op_a) || is_special(w_shl))) begin
              w_next_state = ERROR;
            end else begin
              w_next_state = VALID;
            end
          end else begin
            w_next_count = r_nib_count + 3'd1;
          end
        end else if (nibble_del && (r_nib_count != 3'd0)) begin
          if (r_state == LOAD_A) begin
            w_next_a = w_shr;
          end else begin
            w_next_b = w_shr;
          end
          w_next_count = r_nib_count - 3'd1;
        end else begin
          w_next_count = r_nib_count;
        end
      end
      VALID: begin
        if (op_ready) begin
          w_next_state = LOAD_A;
          w_next_count = 3'd0;
        end else begin
          w_next_state = VALID;
        end
      end
      ERROR: begin
        // The strobe that clears the error is consumed, not captured
        if (nibble_strobe) begin
          w_next_state = LOAD_A;
          w_next_count = 3'd0;
        end else begin
          w_next_state = ERROR;
        end
      end
      default: begin
        w_next_state = LOAD_A;
        w_next_count = 3'd0;
      end
    endcase
  end

  // State, operand and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= LOAD_A;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_nib_count <= 3'd0;
      r_op_valid  <= 1'b0;
      r_op_error  <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_op_a      <= w_next_a;
      r_op_b      <= w_next_b;
      r_nib_count <= w_next_count;
      r_op_valid  <= (w_next_state == VALID);
      r_op_error  <= (w_next_state == ERROR);
    end
  end

  assign op_a       = r_op_a;
  assign op_b       = r_op_b;
  assign op_valid   = r_op_valid;
  assign load_state = r_state;
  assign nib_count  = r_nib_count;
  assign op_error   = r_op_error;

endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 SHALL have parameter N, default 32, operand width in bits; only N=32 is supported.
REQ-002 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL have port nibble_in, input, 4, hex digit being entered.
REQ-005 SHALL have port nibble_strobe, input, 1, debounced single-cycle pulse that captures nibble_in.
REQ-006 SHALL have port nibble_del, input, 1, debounced single-cycle pulse that removes the last entered nibble.
REQ-007 SHALL have port op_ready, input, 1, adder pipeline accepts the operands.
REQ-008 SHALL have port op_a, output, N, operand A for the adder's first register stage.
REQ-009 SHALL have port op_b, output, N, operand B for the adder's first register stage.
REQ-010 SHALL have port op_valid, output, 1, operands complete and stable.
REQ-011 SHALL have port load_state, output, 2, current FSM state, for the status LEDs.
REQ-012 SHALL have port nib_count, output, 3, index of the next nibble within the current operand (0..7).
REQ-013 SHALL have port op_error, output, 1, special operand rejected (see Configuration).

Function
REQ-014 SHALL implement the FSM states LOAD_A=0, LOAD_B=1, VALID=2 and ERROR=3, encoded on load_state.
REQ-015 SHALL, in LOAD_A or LOAD_B on nibble_strobe, shift the active operand left by 4 with nibble_in in bits [3:0], and increment nib_count; entry is MSB first.
REQ-016 SHALL, on a strobe while nib_count=7, set nib_count to 0 and advance LOAD_A->LOAD_B or LOAD_B->VALID.
REQ-017 SHALL, on nibble_del while nib_count>0, shift the active operand right by 4 (zero fill) and decrement nib_count.
REQ-018 SHALL ignore nibble_del when nib_count=0; entry never crosses back from B to A.
REQ-019 SHALL, when nibble_strobe and nibble_del occur in the same cycle, apply the strobe and ignore the delete.
REQ-020 SHALL register op_valid; it is 1 exactly while in VALID, first asserted the cycle after the 16th strobe.
REQ-021 SHALL, in VALID, hold op_a and op_b constant and ignore strobe and delete.
REQ-022 SHALL treat op_valid=1 and op_ready=1 in the same cycle as a transfer; next cycle op_valid=0, state LOAD_A, nib_count=0.
REQ-023 SHALL, after a transfer, leave op_a and op_b at their old values until they are overwritten by shifting.
REQ-024 SHALL ignore op_ready outside VALID.

Reset
REQ-025 SHALL, when reset=1 at a clock edge, set state LOAD_A, nib_count 0, op_a and op_b 0, op_valid 0 and op_error 0, overriding all other inputs.
REQ-026 SHALL, on a reset mid-entry or in VALID, discard partial operands with no transfer.

Configuration
REQ-027 SHALL, when macro SPECIAL_OPERAND_CHECK_EN is defined and the 16th strobe completes B, enter ERROR instead of VALID if either operand's exponent [30:23]=8'hFF.
REQ-028 SHALL, in ERROR, hold op_error=1 and op_valid=0; the next nibble_strobe returns to LOAD_A with nib_count=0 and op_error=0, and that strobe's nibble is not captured.
REQ-029 SHALL, when SPECIAL_OPERAND_CHECK_EN is undefined, tie op_error to 0, leave ERROR unreachable, and always enter VALID after B.

Verification
REQ-030 SHALL cover: enter A=0x03002000 and B=0x00800040 with op_ready=0 -> op_valid=1 the cycle after the 16th strobe, op_a/op_b as entered and held for 10 cycles.
REQ-031 SHALL cover: in VALID, pulse op_ready for one cycle -> next cycle op_valid=0, load_state=0, nib_count=0.
REQ-032 SHALL cover: enter A nibbles 1,2,3, then delete, then 4 -> op_a[11:0]=0x124, nib_count=3; a delete at nib_count=0 in LOAD_B -> no change.
REQ-033 SHALL cover: strobe and delete in the same cycle with nibble_in=0xA -> nibble captured, count +1.
REQ-034 SHALL cover: reset asserted after 11 strobes -> next cycle all outputs at reset values.
REQ-035 SHALL cover: with SPECIAL_OPERAND_CHECK_EN, A=0x7F800000 -> ERROR, op_error=1, op_valid=0; the next strobe -> LOAD_A, op_error=0.
